// File: rtl/idrob_pkg.sv
// Shared definitions for the ID->ROB mid-stage: queue depth, PC width and delay-slot FSM encoding.
package idrob_pkg;

  localparam int IDROB_DEPTH = 2;
  localparam int ADDR_BUS    = 32;

  typedef enum logic {
    DS_NORMAL = 1'b0,
    DS_WAIT   = 1'b1
  } ds_state_e;

  // One queue entry holds {payload, pc, is_delayslot, branch_pc}
  function automatic int entry_w(input int payload_w, input int addr_w);
    return payload_w + 2 * addr_w + 1;
  endfunction

endpackage

// File: rtl/idrob_fifo.sv
// Two-entry synchronous FIFO with registered head data, full/empty flags and count.
module idrob_fifo
  import idrob_pkg::*;
#(
  parameter int W = 225
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [IDROB_DEPTH];
  logic         wr_ptr_r, rd_ptr_r;
  logic [1:0]   count_r;
  logic [W-1:0] dout_r;
  logic         full_r, empty_r;

  logic         push_s, pop_s;
  logic         wr_ptr_s, rd_ptr_s;
  logic [1:0]   count_s;
  logic [W-1:0] dout_s;

  // Next pointers/count and the head entry as it will look after this edge
  always_comb begin
    push_s   = push & ~full_r & ~flush;
    pop_s    = pop & ~empty_r & ~flush;
    wr_ptr_s = wr_ptr_r ^ push_s;
    rd_ptr_s = rd_ptr_r ^ pop_s;
    count_s  = count_r + {1'b0, push_s} - {1'b0, pop_s};
    dout_s   = '0;
    if (flush || (count_s == 2'd0)) begin
      dout_s = '0;
    end else if (push_s && (wr_ptr_r == rd_ptr_s)) begin
      dout_s = din;
    end else begin
      dout_s = mem_r[rd_ptr_s];
    end
  end

  // Storage, pointers and registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IDROB_DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      dout_r   <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      dout_r   <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) mem_r[wr_ptr_r] <= din;
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
      dout_r   <= dout_s;
      full_r   <= (count_s == 2'd2);
      empty_r  <= (count_s == 2'd0);
    end
  end

  assign dout  = dout_r;
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;

endmodule

// File: rtl/idrob_ctrl.sv
// ID->ROB mid-stage controller: 2-entry skid queue plus branch delay-slot tracking and tagging.
module idrob_ctrl
  import idrob_pkg::*;
#(
  parameter int PAYLOAD_W = 160,
  parameter int ADDR_W    = ADDR_BUS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [PAYLOAD_W-1:0] id_payload,
  input  logic [ADDR_W-1:0]    id_pc,
  input  logic                 id_is_next_delayslot,
  output logic                 is_current_delayslot,
  output logic                 rob_valid,
  input  logic                 rob_ready,
  output logic [PAYLOAD_W-1:0] rob_payload,
  output logic [ADDR_W-1:0]    rob_pc,
  output logic                 rob_is_delayslot,
  output logic [ADDR_W-1:0]    rob_branch_pc,
  output logic [1:0]           occupancy
);

  localparam int ENTRY_W = entry_w(PAYLOAD_W, ADDR_W);

  ds_state_e           state_r, state_s;
  logic [ADDR_W-1:0]   ds_branch_pc_r, ds_branch_pc_s;
  logic                tag_ds_s;
  logic [ADDR_W-1:0]   tag_pc_s;
  logic                push_s, pop_s;
  logic                full_s, empty_s;
  logic [ENTRY_W-1:0]  din_s, dout_s;

  // id_ready/rob_valid come straight from registered FIFO flags, so no comb path from rob_ready
  assign id_ready  = ~full_s;
  assign rob_valid = ~empty_s;
  assign push_s    = id_valid & id_ready;
  assign pop_s     = rob_valid & rob_ready;

  // Delay-slot FSM next state and tagging of the instruction being accepted
  always_comb begin
    state_s        = state_r;
    ds_branch_pc_s = ds_branch_pc_r;
    tag_ds_s       = 1'b0;
    tag_pc_s       = '0;
    case (state_r)
      DS_NORMAL: begin
        if (push_s && id_is_next_delayslot) begin
          state_s        = DS_WAIT;
          ds_branch_pc_s = id_pc;
        end else begin
          state_s = DS_NORMAL;
        end
      end
      DS_WAIT: begin
        if (push_s) begin
          tag_ds_s = 1'b1;
          tag_pc_s = ds_branch_pc_r;
          if (id_is_next_delayslot) begin
            state_s        = DS_WAIT;
            ds_branch_pc_s = id_pc;
          end else begin
            state_s        = DS_NORMAL;
            ds_branch_pc_s = '0;
          end
        end else begin
          state_s = DS_WAIT;
        end
      end
      default: begin
        state_s        = DS_NORMAL;
        ds_branch_pc_s = '0;
      end
    endcase
  end

  // FSM state and owning-branch PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= DS_NORMAL;
      ds_branch_pc_r <= '0;
    end else if (flush) begin
      state_r        <= DS_NORMAL;
      ds_branch_pc_r <= '0;
    end else begin
      state_r        <= state_s;
      ds_branch_pc_r <= ds_branch_pc_s;
    end
  end

  assign is_current_delayslot = (state_r == DS_WAIT);
  assign din_s = {id_payload, id_pc, tag_ds_s, tag_pc_s};

  idrob_fifo #(.W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push_s),
    .pop   (pop_s),
    .din   (din_s),
    .dout  (dout_s),
    .full  (full_s),
    .empty (empty_s),
    .count (occupancy)
  );

  assign {rob_payload, rob_pc, rob_is_delayslot, rob_branch_pc} = dout_s;

endmodule

// File: tb/tb_idrob_ctrl.sv
// Directed self-checking bench for idrob_ctrl with hand-computed expected values.
module tb_idrob_ctrl;

  logic         clk = 1'b0;
  logic         rst, flush, id_valid, id_ready, id_is_next_delayslot;
  logic [159:0] id_payload;
  logic [31:0]  id_pc;
  logic         is_current_delayslot, rob_valid, rob_ready, rob_is_delayslot;
  logic [159:0] rob_payload;
  logic [31:0]  rob_pc, rob_branch_pc;
  logic [1:0]   occupancy;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  idrob_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .id_valid             (id_valid),
    .id_ready             (id_ready),
    .id_payload           (id_payload),
    .id_pc                (id_pc),
    .id_is_next_delayslot (id_is_next_delayslot),
    .is_current_delayslot (is_current_delayslot),
    .rob_valid            (rob_valid),
    .rob_ready            (rob_ready),
    .rob_payload          (rob_payload),
    .rob_pc               (rob_pc),
    .rob_is_delayslot     (rob_is_delayslot),
    .rob_branch_pc        (rob_branch_pc),
    .occupancy            (occupancy)
  );

  task automatic check_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic br);
    id_valid             = v;
    id_pc                = pc;
    id_is_next_delayslot = br;
    id_payload           = {5{pc ^ 32'hC0DE_0000}};
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic ds,
                            input logic [31:0] br);
    check_vec({tag, "_pc"}, 64'(rob_pc), 64'(pc));
    check_vec({tag, "_pay"}, rob_payload[63:0], {2{pc ^ 32'hC0DE_0000}});
    check_vec({tag, "_ds"}, 64'(rob_is_delayslot), 64'(ds));
    check_vec({tag, "_brpc"}, 64'(rob_branch_pc), 64'(br));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rob_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    step(); step();
    rst = 1'b0;
    // 1 reset state
    check_vec("rst_id_ready", 64'(id_ready), 64'd1);
    check_vec("rst_rob_valid", 64'(rob_valid), 64'd0);
    check_vec("rst_occ", 64'(occupancy), 64'd0);
    check_vec("rst_cur_ds", 64'(is_current_delayslot), 64'd0);
    check_vec("rst_rob_pc", 64'(rob_pc), 64'd0);

    // 2 fill with stalled ROB, then drain in order
    drive(1'b1, 32'h100, 1'b0); step();
    check_vec("fill1_occ", 64'(occupancy), 64'd1);
    check_vec("fill1_valid", 64'(rob_valid), 64'd1);
    check_head("fill1", 32'h100, 1'b0, 32'h0);
    drive(1'b1, 32'h104, 1'b0); step();
    check_vec("fill2_occ", 64'(occupancy), 64'd2);
    check_vec("fill2_id_ready", 64'(id_ready), 64'd0);
    check_head("fill2", 32'h100, 1'b0, 32'h0);
    drive(1'b1, 32'h108, 1'b0); step();
    check_vec("stall_occ", 64'(occupancy), 64'd2);
    check_head("stall", 32'h100, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0); rob_ready = 1'b1; step();
    check_vec("pop1_occ", 64'(occupancy), 64'd1);
    check_vec("pop1_id_ready", 64'(id_ready), 64'd1);
    check_head("pop1", 32'h104, 1'b0, 32'h0);
    step();
    check_vec("pop2_occ", 64'(occupancy), 64'd0);
    check_vec("pop2_valid", 64'(rob_valid), 64'd0);
    check_vec("pop2_rob_pc", 64'(rob_pc), 64'd0);

    // 3 single delay slot, ROB consuming every cycle
    drive(1'b1, 32'h200, 1'b1); step();
    check_vec("ds_cur1", 64'(is_current_delayslot), 64'd1);
    check_head("ds_br", 32'h200, 1'b0, 32'h0);
    drive(1'b1, 32'h204, 1'b0); step();
    check_vec("ds_cur2", 64'(is_current_delayslot), 64'd0);
    check_vec("ds_occ", 64'(occupancy), 64'd1);
    check_head("ds_slot", 32'h204, 1'b1, 32'h200);
    drive(1'b0, 32'h0, 1'b0); step();
    check_vec("ds_drain", 64'(occupancy), 64'd0);

    // 4 branch sitting in a delay slot
    drive(1'b1, 32'h300, 1'b1); step();
    check_vec("bb_cur1", 64'(is_current_delayslot), 64'd1);
    check_head("bb_300", 32'h300, 1'b0, 32'h0);
    drive(1'b1, 32'h304, 1'b1); step();
    check_vec("bb_cur2", 64'(is_current_delayslot), 64'd1);
    check_head("bb_304", 32'h304, 1'b1, 32'h300);
    drive(1'b1, 32'h308, 1'b0); step();
    check_vec("bb_cur3", 64'(is_current_delayslot), 64'd0);
    check_head("bb_308", 32'h308, 1'b1, 32'h304);
    drive(1'b0, 32'h0, 1'b0); step();

    // 5 flush with full queue in DS_WAIT, push and pop both requested
    rob_ready = 1'b0;
    drive(1'b1, 32'h400, 1'b0); step();
    drive(1'b1, 32'h404, 1'b1); step();
    check_vec("fl_pre_occ", 64'(occupancy), 64'd2);
    check_vec("fl_pre_cur", 64'(is_current_delayslot), 64'd1);
    flush = 1'b1; rob_ready = 1'b1; drive(1'b1, 32'h408, 1'b0); step();
    flush = 1'b0; drive(1'b0, 32'h0, 1'b0);
    check_vec("fl_occ", 64'(occupancy), 64'd0);
    check_vec("fl_valid", 64'(rob_valid), 64'd0);
    check_vec("fl_cur", 64'(is_current_delayslot), 64'd0);
    check_vec("fl_id_ready", 64'(id_ready), 64'd1);
    check_vec("fl_rob_pc", 64'(rob_pc), 64'd0);
    step();
    check_vec("fl_hold_occ", 64'(occupancy), 64'd0);

    // 6 steady stream: one in, one out each cycle
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 1'b0); step();
      check_vec("st_occ", 64'(occupancy), 64'd1);
      check_vec("st_pc", 64'(rob_pc), 64'(32'h500 + 32'(4 * i)));
    end
    drive(1'b0, 32'h0, 1'b0); step();
    check_vec("st_end_occ", 64'(occupancy), 64'd0);

    // reset mid-stream drops entries and delay-slot state
    rob_ready = 1'b0;
    drive(1'b1, 32'h600, 1'b1); step();
    check_vec("mr_pre_cur", 64'(is_current_delayslot), 64'd1);
    rst = 1'b1; flush = 1'b1; step();
    rst = 1'b0; flush = 1'b0; drive(1'b0, 32'h0, 1'b0);
    check_vec("mr_occ", 64'(occupancy), 64'd0);
    check_vec("mr_cur", 64'(is_current_delayslot), 64'd0);
    check_vec("mr_rob_pc", 64'(rob_pc), 64'd0);
    check_vec("mr_id_ready", 64'(id_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
